// File: rtl/uart_tx_frm.sv
// UART frame transmitter: start, 8 data bits LSB first, parity, stop, optional idle gap.
// Define UART_TX_TWO_STOP_EN to send a second stop bit (STOP2) before the idle gap.
module uart_tx_frm #(
   parameter bit          ODD_PARITY = 1'b0,
   parameter int unsigned IDLE_GAP   = 0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       baud_tick,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready,
   output logic       tx,
   output logic       tx_busy,
   output logic       tx_done
);

`ifdef UART_TX_TWO_STOP_EN
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, STOP2, GAP} state_t;
`else
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, GAP} state_t;
`endif

   localparam logic [3:0] GAP_INIT = 4'(IDLE_GAP);

   state_t     state;
   logic [7:0] shift;
   logic [2:0] count;
   logic [3:0] gap;
   logic       parity_bit;

   assign tx_ready = (state == IDLE);
   assign tx_busy  = ~tx_ready;

   // A tick coinciding with acceptance is dropped: IDLE never looks at baud_tick.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         tx         <= 1'b1;
         tx_done    <= 1'b0;
         shift      <= 8'h00;
         count      <= 3'd0;
         gap        <= 4'd0;
         parity_bit <= 1'b0;
      end else begin
         tx_done <= 1'b0;
         case (state)
            IDLE: begin
               if (tx_valid) begin
                  shift      <= tx_data;
                  parity_bit <= (^tx_data) ^ ODD_PARITY;
                  state      <= START;
               end
            end
            START: begin
               if (baud_tick) begin
                  tx    <= 1'b0;
                  count <= 3'd0;
                  state <= DATA;
               end
            end
            DATA: begin
               if (baud_tick) begin
                  tx    <= shift[0];
                  shift <= {1'b0, shift[7:1]};
                  if (count == 3'd7) begin
                     state <= PARITY;
                  end else begin
                     count <= count + 3'd1;
                  end
               end
            end
            PARITY: begin
               if (baud_tick) begin
                  tx    <= parity_bit;
                  state <= STOP;
               end
            end
            STOP: begin
               if (baud_tick) begin
                  tx <= 1'b1;
`ifdef UART_TX_TWO_STOP_EN
                  state <= STOP2;
`else
                  state <= GAP;
                  gap   <= GAP_INIT;
`endif
               end
            end
`ifdef UART_TX_TWO_STOP_EN
            STOP2: begin
               if (baud_tick) begin
                  tx    <= 1'b1;
                  state <= GAP;
                  gap   <= GAP_INIT;
               end
            end
`endif
            // The tick that finds the gap counter at zero ends the frame.
            GAP: begin
               if (baud_tick) begin
                  tx <= 1'b1;
                  if (gap == 4'd0) begin
                     state   <= IDLE;
                     tx_done <= 1'b1;
                  end else begin
                     gap <= gap - 4'd1;
                  end
               end
            end
            default: begin
               state <= IDLE;
               tx    <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_frm.sv
// Testbench for uart_tx_frm: two instances (default and ODD_PARITY=1/IDLE_GAP=2)
// checked against a per-tick line model built from the frame format.
module tb_uart_tx_frm;

   localparam int LIMIT = 200;
`ifdef UART_TX_TWO_STOP_EN
   localparam int EXTRA_STOP = 1;
`else
   localparam int EXTRA_STOP = 0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        baud_tick = 1'b0;
   logic [1:0]  vld;
   logic [15:0] dat;
   logic [1:0]  txl, rdy, bsy, dn;

   int checks = 0;
   int failures = 0;
   int tick_period = 4;
   int tick_cnt = 0;
   int done_cnt [2] = '{0, 0};
   int exp_done [2] = '{0, 0};

   uart_tx_frm #(.ODD_PARITY(1'b0), .IDLE_GAP(0)) dut0 (
      .clk(clk), .rst(rst), .baud_tick(baud_tick),
      .tx_data(dat[7:0]), .tx_valid(vld[0]), .tx_ready(rdy[0]),
      .tx(txl[0]), .tx_busy(bsy[0]), .tx_done(dn[0])
   );

   uart_tx_frm #(.ODD_PARITY(1'b1), .IDLE_GAP(2)) dut1 (
      .clk(clk), .rst(rst), .baud_tick(baud_tick),
      .tx_data(dat[15:8]), .tx_valid(vld[1]), .tx_ready(rdy[1]),
      .tx(txl[1]), .tx_busy(bsy[1]), .tx_done(dn[1])
   );

   always #5 clk = ~clk;

   // Tick strobe updated on the falling edge so it is stable at every rising edge.
   initial begin
      forever begin
         @(negedge clk);
         tick_cnt++;
         if (tick_cnt >= tick_period) begin
            tick_cnt  = 0;
            baud_tick = 1'b1;
         end else begin
            baud_tick = 1'b0;
         end
      end
   end

   // Every clk spent with tx_done high is counted, so a stretched pulse shows up.
   always @(negedge clk) begin
      if (dn[0]) done_cnt[0]++;
      if (dn[1]) done_cnt[1]++;
   end

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("[TB] FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int oddOf(input int u);
      return (u == 1) ? 1 : 0;
   endfunction

   function automatic int gapOf(input int u);
      return (u == 1) ? 2 : 0;
   endfunction

   // Sends one byte on unit u and checks the line after every tick.
   // abortAt>0 asserts rst between ticks after that many ticks; poke drives a
   // rejected byte mid-frame; b2b expects acceptance in the tx_done cycle.
   task automatic applyStimulus(input int u, input logic [7:0] b, input int abortAt,
                                input bit poke, input bit b2b);
      bit q[$];
      int n;
      bit last;
      q = {};
      q.push_back(1'b0);
      for (int i = 0; i < 8; i++) q.push_back(b[i]);
      q.push_back(bit'((($countones(b) + oddOf(u)) % 2) == 1));
      q.push_back(1'b1);
      for (int i = 0; i < EXTRA_STOP; i++) q.push_back(1'b1);
      for (int i = 0; i <= gapOf(u); i++) q.push_back(1'b1);

      dat[u*8 +: 8] = b;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!rdy[u] && n < LIMIT);
      if (!rdy[u]) begin
         checkOutput("accept_timeout", 0, 1);
         return;
      end
      if (b2b) checkOutput("b2b_in_done_cycle", dn[u], 1);
      vld[u] = 1'b1;
      @(posedge clk);
      #1;
      vld[u] = 1'b0;
      dat[u*8 +: 8] = 8'($urandom);
      checkOutput("accept_tx_high", txl[u], 1);
      checkOutput("accept_ready_low", rdy[u], 0);
      checkOutput("accept_busy", bsy[u], 1);
      checkOutput("done_count", done_cnt[u], exp_done[u]);

      for (int k = 0; k < q.size(); k++) begin
         n = 0;
         do begin
            @(posedge clk);
            n++;
         end while (!baud_tick && n < LIMIT);
         if (!baud_tick) begin
            checkOutput("tick_timeout", 0, 1);
            return;
         end
         #1;
         last = (k == q.size() - 1);
         checkOutput($sformatf("tx_bit%0d", k), txl[u], q[k]);
         checkOutput("ready", rdy[u], last);
         checkOutput("busy", bsy[u], !last);
         checkOutput("done", dn[u], last);
         if (poke && k == 4) begin
            dat[u*8 +: 8] = 8'hFF;
            vld[u] = 1'b1;
         end
         if (poke && k == 5) vld[u] = 1'b0;
         if (abortAt != 0 && k + 1 == abortAt) begin
            @(negedge clk);
            rst = 1'b1;
            #1;
            checkOutput("abort_tx", txl[u], 1);
            checkOutput("abort_ready", rdy[u], 1);
            checkOutput("abort_busy", bsy[u], 0);
            checkOutput("abort_done", dn[u], 0);
            @(negedge clk);
            rst = 1'b0;
            return;
         end
      end
      exp_done[u]++;
   endtask

   initial begin
      rst = 1'b1;
      vld = 2'b00;
      dat = 16'h0000;
      #1;
      for (int u = 0; u < 2; u++) begin
         checkOutput("reset_tx", txl[u], 1);
         checkOutput("reset_ready", rdy[u], 1);
         checkOutput("reset_busy", bsy[u], 0);
         checkOutput("reset_done", dn[u], 0);
      end
      vld = 2'b11;
      repeat (3) @(negedge clk);
      checkOutput("valid_during_reset", rdy, 2'b11);
      vld = 2'b00;
      rst = 1'b0;

      tick_period = 4;
      applyStimulus(0, 8'hA5, 0, 1'b0, 1'b0);
      applyStimulus(0, 8'h55, 0, 1'b0, 1'b0);
      applyStimulus(0, 8'h0F, 0, 1'b0, 1'b1);
      applyStimulus(0, 8'h12, 0, 1'b1, 1'b0);
      applyStimulus(0, 8'h3C, 5, 1'b0, 1'b0);
      applyStimulus(0, 8'h81, 0, 1'b0, 1'b0);
      applyStimulus(1, 8'h01, 0, 1'b0, 1'b0);

      tick_period = 1;
      applyStimulus(0, 8'h00, 0, 1'b0, 1'b0);
      applyStimulus(0, 8'hFF, 0, 1'b0, 1'b1);
      applyStimulus(1, 8'h3C, 0, 1'b0, 1'b0);
      applyStimulus(1, 8'hC3, 0, 1'b0, 1'b1);

      for (int i = 0; i < 12; i++) begin
         tick_period = $urandom_range(1, 5);
         applyStimulus(int'($urandom_range(0, 1)), 8'($urandom), 0, 1'b0, 1'b0);
      end

      repeat (10) @(negedge clk);
      #1;
      checkOutput("final_done_count0", done_cnt[0], exp_done[0]);
      checkOutput("final_done_count1", done_cnt[1], exp_done[1]);
      checkOutput("final_idle", {rdy, txl}, 4'b1111);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
